// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic handshaked pipeline stage register for the 5-stage core.
// Carries a control bundle and a data bundle under valid/ready with stall,
// synchronous flush (bubble insertion) and an asynchronous active-low reset.
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid build with
// a registered in_ready. Leave it undefined for the single-register build.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   // Main register: always the beat presented downstream.
   logic [CTRL_W-1:0] main_ctrl_reg;
   logic [DATA_W-1:0] main_data_reg;

   logic accept;
   logic fire;

   assign fire     = out_valid & out_ready;
   assign out_data = main_data_reg;

   // A bubble must look like a NOP, so control bits are gated by valid.
   // Data is left ungated and simply holds its last value.
   genvar gi;
   generate
      for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
         assign out_ctrl[gi] = main_ctrl_reg[gi] & out_valid;
      end
   endgenerate

`ifdef PIPE_STAGE_SKID_EN

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            state_reg;
   logic              in_ready_reg;
   logic [CTRL_W-1:0] skid_ctrl_reg;
   logic [DATA_W-1:0] skid_data_reg;

   assign in_ready  = in_ready_reg;
   assign accept    = in_valid & in_ready_reg;
   assign out_valid = (state_reg != ST_EMPTY);
   assign occupancy = state_reg;

   // Skid FSM. in_ready is set alongside each state change to equal
   // (next state != TWO), so it never depends on out_ready in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_EMPTY;
         in_ready_reg  <= 1'b1;
         main_ctrl_reg <= '0;
         main_data_reg <= '0;
         skid_ctrl_reg <= '0;
         skid_data_reg <= '0;
      end else if (flush) begin
         state_reg    <= ST_EMPTY;
         in_ready_reg <= 1'b1;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (accept) begin
                  main_ctrl_reg <= in_ctrl;
                  main_data_reg <= in_data;
                  state_reg     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && fire) begin
                  main_ctrl_reg <= in_ctrl;
                  main_data_reg <= in_data;
               end else if (accept) begin
                  skid_ctrl_reg <= in_ctrl;
                  skid_data_reg <= in_data;
                  state_reg     <= ST_TWO;
                  in_ready_reg  <= 1'b0;
               end else if (fire) begin
                  state_reg <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (fire) begin
                  main_ctrl_reg <= skid_ctrl_reg;
                  main_data_reg <= skid_data_reg;
                  state_reg     <= ST_ONE;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg    <= ST_EMPTY;
               in_ready_reg <= 1'b1;
            end
         endcase
      end
   end

`else

   logic valid_reg;

   assign out_valid = valid_reg;
   assign in_ready  = out_ready | ~valid_reg;
   assign accept    = in_valid & in_ready;
   assign occupancy = {1'b0, valid_reg};

   // Single register: load on accept, empty on a fire with nothing behind it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_reg     <= 1'b0;
         main_ctrl_reg <= '0;
         main_data_reg <= '0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (accept) begin
         main_ctrl_reg <= in_ctrl;
         main_data_reg <= in_data;
         valid_reg     <= 1'b1;
      end else if (fire) begin
         valid_reg <= 1'b0;
      end
   end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: a table-driven stream, hand-written stall,
// flush and asynchronous-reset sequences, then a randomised scoreboard run.
// Expectations follow PIPE_STAGE_SKID_EN so that either build can be checked.
module tb_pipe_stage_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [7:0]  ic;
      logic [31:0] id;
      logic        ordy;
      logic        ev;
      logic [7:0]  ec;
      logic [31:0] ed;
      logic [1:0]  eo;
      logic        eir;
   } vec_t;

   vec_t tbl [12];

   logic [39:0] sb [$];

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // One cycle: drive inputs just after a rising edge, check at the falling
   // edge (state before the next edge), then advance past the next edge.
   task automatic cyc(input string nm, input logic fl, input logic iv,
                      input logic [7:0] ic, input logic [31:0] id, input logic ordy,
                      input logic ev, input logic [7:0] ec, input logic [31:0] ed,
                      input logic [1:0] eo, input logic eir);
      flush     = fl;
      in_valid  = iv;
      in_ctrl   = ic;
      in_data   = id;
      out_ready = ordy;
      @(negedge clk);
      chk({nm, "_valid"}, out_valid, ev);
      chk({nm, "_ctrl"}, out_ctrl, ec);
      chk({nm, "_data"}, out_data, ed);
      chk({nm, "_occ"}, occupancy, eo);
      chk({nm, "_inrdy"}, in_ready, eir);
      $display("[TB] %s: v=%0d ctrl=%02h data=%08h occ=%0d in_ready=%0d",
               nm, out_valid, out_ctrl, out_data, occupancy, in_ready);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        prev_stall;
      logic [7:0]  prev_ctrl;
      logic [31:0] prev_data;
      logic [39:0] head;
      logic        exp_ir;

      // Stream table: 10 beats back to back with out_ready held high.
      for (int i = 0; i < 12; i++) begin
         tbl[i].fl   = 1'b0;
         tbl[i].iv   = (i < 10);
         tbl[i].ic   = 8'(i + 1);
         tbl[i].id   = 32'h100 + 32'(i);
         tbl[i].ordy = 1'b1;
         tbl[i].ev   = (i >= 1) && (i <= 10);
         tbl[i].ec   = tbl[i].ev ? 8'(i) : 8'h00;
         tbl[i].ed   = (i == 0) ? 32'h0 : ((i == 11) ? 32'h109 : 32'h100 + 32'(i - 1));
         tbl[i].eo   = tbl[i].ev ? 2'd1 : 2'd0;
         tbl[i].eir  = 1'b1;
      end

      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_occ", occupancy, 2'd0);
      chk("reset_inrdy", in_ready, 1'b1);
      reset = 1'b1;

      for (int i = 0; i < 12; i++)
         cyc($sformatf("stream%0d", i), tbl[i].fl, tbl[i].iv, tbl[i].ic, tbl[i].id,
             tbl[i].ordy, tbl[i].ev, tbl[i].ec, tbl[i].ed, tbl[i].eo, tbl[i].eir);

`ifdef PIPE_STAGE_SKID_EN
      // Stall: A0 and A1 are taken, A2 waits on in_ready, order preserved.
      cyc("stall0", 0, 1, 8'hA0, 32'hA0, 0, 0, 8'h00, 32'h109, 2'd0, 1);
      cyc("stall1", 0, 1, 8'hA1, 32'hA1, 0, 1, 8'hA0, 32'hA0, 2'd1, 1);
      cyc("stall2", 0, 1, 8'hA2, 32'hA2, 0, 1, 8'hA0, 32'hA0, 2'd2, 0);
      cyc("stall3", 0, 1, 8'hA2, 32'hA2, 1, 1, 8'hA0, 32'hA0, 2'd2, 0);
      cyc("stall4", 0, 1, 8'hA2, 32'hA2, 1, 1, 8'hA1, 32'hA1, 2'd1, 1);
      cyc("stall5", 0, 0, 8'h00, 32'h0, 1, 1, 8'hA2, 32'hA2, 2'd1, 1);
      cyc("stall6", 0, 0, 8'h00, 32'h0, 1, 0, 8'h00, 32'hA2, 2'd0, 1);
      // Flush with two beats held while 0xBB is offered.
      cyc("flush0", 0, 1, 8'hB0, 32'hB0, 0, 0, 8'h00, 32'hA2, 2'd0, 1);
      cyc("flush1", 0, 1, 8'hB1, 32'hB1, 0, 1, 8'hB0, 32'hB0, 2'd1, 1);
      cyc("flush2", 1, 1, 8'hBB, 32'hBB, 0, 1, 8'hB0, 32'hB0, 2'd2, 0);
      cyc("flush3", 0, 0, 8'h00, 32'h0, 1, 0, 8'h00, 32'hB0, 2'd0, 1);
      cyc("flush4", 0, 0, 8'h00, 32'h0, 1, 0, 8'h00, 32'hB0, 2'd0, 1);
`else
      // Stall: A1 waits on in_ready while A0 is held, order preserved.
      cyc("stall0", 0, 1, 8'hA0, 32'hA0, 0, 0, 8'h00, 32'h109, 2'd0, 1);
      cyc("stall1", 0, 1, 8'hA1, 32'hA1, 0, 1, 8'hA0, 32'hA0, 2'd1, 0);
      cyc("stall2", 0, 1, 8'hA1, 32'hA1, 0, 1, 8'hA0, 32'hA0, 2'd1, 0);
      cyc("stall3", 0, 1, 8'hA1, 32'hA1, 1, 1, 8'hA0, 32'hA0, 2'd1, 1);
      cyc("stall4", 0, 1, 8'hA2, 32'hA2, 1, 1, 8'hA1, 32'hA1, 2'd1, 1);
      cyc("stall5", 0, 0, 8'h00, 32'h0, 1, 1, 8'hA2, 32'hA2, 2'd1, 1);
      cyc("stall6", 0, 0, 8'h00, 32'h0, 1, 0, 8'h00, 32'hA2, 2'd0, 1);
      // Flush while B0 fires and 0xBB is accepted: the fire completes, 0xBB is dropped.
      cyc("flush0", 0, 1, 8'hB0, 32'hB0, 0, 0, 8'h00, 32'hA2, 2'd0, 1);
      cyc("flush1", 1, 1, 8'hBB, 32'hBB, 1, 1, 8'hB0, 32'hB0, 2'd1, 1);
      cyc("flush2", 0, 0, 8'h00, 32'h0, 1, 0, 8'h00, 32'hB0, 2'd0, 1);
      cyc("flush3", 0, 0, 8'h00, 32'h0, 1, 0, 8'h00, 32'hB0, 2'd0, 1);
`endif

      // Asynchronous reset between edges with a beat held.
      cyc("rst0", 0, 1, 8'hC0, 32'hC0, 0, 0, 8'h00, 32'hB0, 2'd0, 1);
      in_valid = 1'b0;
      #2;
      chk("rst_held_valid", out_valid, 1'b1);
      reset = 1'b0;
      #1;
      chk("rst_async_valid", out_valid, 1'b0);
      chk("rst_async_ctrl", out_ctrl, 8'h00);
      chk("rst_async_data", out_data, 32'h0);
      chk("rst_async_occ", occupancy, 2'd0);
      chk("rst_async_inrdy", in_ready, 1'b1);
      $display("[TB] async reset: v=%0d ctrl=%02h data=%08h", out_valid, out_ctrl, out_data);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc("rst1", 0, 1, 8'hD0, 32'hD0, 1, 0, 8'h00, 32'h0, 2'd0, 1);
      cyc("rst2", 0, 0, 8'h00, 32'h0, 1, 1, 8'hD0, 32'hD0, 2'd1, 1);
      cyc("rst3", 0, 0, 8'h00, 32'h0, 1, 0, 8'h00, 32'hD0, 2'd0, 1);

      // Randomised traffic against an in-order scoreboard.
      sb.delete();
      prev_stall = 1'b0;
      prev_ctrl  = '0;
      prev_data  = '0;
      for (int c = 0; c < 2000; c++) begin
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_ctrl   = 8'($urandom);
         in_data   = $urandom;
         @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
         exp_ir = (sb.size() != 2);
`else
         exp_ir = out_ready | (sb.size() == 0);
`endif
         chk("rnd_occ", occupancy, sb.size());
         chk("rnd_valid", out_valid, sb.size() != 0);
         chk("rnd_inrdy", in_ready, exp_ir);
         if (!out_valid)
            chk("rnd_bubble_ctrl", out_ctrl, 8'h00);
         if (prev_stall) begin
            chk("rnd_hold_ctrl", out_ctrl, prev_ctrl);
            chk("rnd_hold_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("rnd_fire_unexpected", 1'b1, 1'b0);
            end else begin
               head = sb.pop_front();
               chk("rnd_fire_beat", {out_ctrl, out_data}, head);
            end
         end
         if (flush)
            sb.delete();
         else if (in_valid && in_ready)
            sb.push_back({in_ctrl, in_data});
         prev_stall = out_valid & ~out_ready & ~flush;
         prev_ctrl  = out_ctrl;
         prev_data  = out_data;
         @(posedge clk);
         #1;
      end
      $display("[TB] random run done, %0d beats left in stage", sb.size());

      flush    = 1'b0;
      in_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
